// File: rtl/apb_master_bridge.sv
// APB initiator: one local command in, one APB transfer out, one rsp_valid pulse back; accept-to-response 3 cycles plus wait states.
// cmd_ready only in IDLE (one transfer in flight), response port has no backpressure; APB_TIMEOUT_EN adds a wait-state abort.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             timeout_hit;

    // Reaching the limit means this edge is the TIMEOUT_CYCLES-th wait cycle.
    assign timeout_hit = (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_d    = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                    state_d     = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: randomized commands against a memory-level reference model.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    int checks = 0;
    int failures = 0;

    // Slave memory is written from what appears on the bus; the reference
    // memory is written from the commands issued.
    bit [31:0] slv_mem [bit [31:0]];
    bit [31:0] ref_mem [bit [31:0]];

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] rd_slv(input bit [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    endfunction

    function automatic bit [31:0] rd_ref(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // One full command with nwait wait states; slave answers with err.
    task automatic do_xfer(input bit w, input bit [31:0] a, input bit [31:0] d,
                           input int nwait, input bit err, input string nm);
        int guard;
        int en_cnt;
        int lat;
        bit [31:0] exp;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_wait: cmd_ready=%b want 1", nm, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        lat = 1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== w || paddr !== a ||
            pwdata !== d || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s setup: psel=%b pen=%b pw=%b paddr=%h pwdata=%h rdy=%b want 1 0 %b %h %h 0",
                     nm, psel, penable, pwrite, paddr, pwdata, cmd_ready, w, a, d);
        end
        @(posedge clk); #1;
        lat++;
        en_cnt = 1;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || paddr !== a) begin
            failures++;
            $display("FAIL %s access: psel=%b pen=%b paddr=%h want 1 1 %h", nm, psel, penable, paddr, a);
        end
        for (int i = 0; i < nwait; i++) begin
            pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (penable === 1'b1) en_cnt++;
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== a || pwdata !== d ||
                pwrite !== w || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s wait%0d: psel=%b pen=%b paddr=%h rsp_valid=%b want 1 1 %h 0",
                         nm, i, psel, penable, paddr, rsp_valid, a);
            end
        end
        pready = 1'b1; pslverr = err;
        prdata = pwrite ? $urandom : rd_slv(paddr);
        if (pwrite && !err) slv_mem[paddr] = pwdata;
        @(posedge clk); #1;
        lat++;
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        exp = (!w && !err) ? rd_ref(a) : 32'h0;
        if (w && !err) ref_mem[a] = d;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== err || rsp_rdata !== exp) begin
            failures++;
            $display("FAIL %s rsp: valid=%b err=%b rdata=%h want 1 %b %h", nm, rsp_valid, rsp_err, rsp_rdata, err, exp);
        end
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s end: psel=%b pen=%b rdy=%b want 0 0 1", nm, psel, penable, cmd_ready);
        end
        checks++;
        if (en_cnt !== nwait + 1 || lat !== nwait + 3) begin
            failures++;
            $display("FAIL %s timing: penable_cycles=%0d latency=%0d want %0d %0d", nm, en_cnt, lat, nwait + 1, nwait + 3);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== exp || rsp_err !== err || paddr !== a || pwrite !== w) begin
            failures++;
            $display("FAIL %s hold: valid=%b rdata=%h err=%b paddr=%h pw=%b want 0 %h %b %h %b",
                     nm, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, exp, err, a, w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 || paddr !== 0 || pwdata !== 0 ||
            rsp_rdata !== 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: psel=%b pen=%b pw=%b rv=%b re=%b paddr=%h pwdata=%h rdata=%h rdy=%b want all 0, rdy 1",
                     psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        slv_mem[20] = 32'd99;
        ref_mem[20] = 32'd99;
        do_xfer(1'b1, 32'd5, 32'hA5A5_0001, 0, 1'b0, "wr5");
        do_xfer(1'b0, 32'd5, 32'h0, 0, 1'b0, "rd5");
        do_xfer(1'b0, 32'd20, 32'h0, 0, 1'b0, "rd20");
        do_xfer(1'b0, 32'd10, 32'h0, 3, 1'b0, "rd10_wait3");
        do_xfer(1'b1, 32'd12, 32'h1234_5678, 0, 1'b1, "wr12_err");
        do_xfer(1'b0, 32'd12, 32'h0, 1, 1'b0, "rd12_after_err");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            do_xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 4), ($urandom_range(0, 7) == 0), "rand");
        end
    endtask

    task automatic test_back_to_back();
        bit prev_rdy, prev_rsp;
        int last_acc, n_acc, n_rsp, guard;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_1234;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd7;
        prev_rdy = cmd_ready; prev_rsp = rsp_valid;
        last_acc = -1; n_acc = 0; n_rsp = 0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (prev_rdy) begin
                n_acc++;
                if (last_acc >= 0) begin
                    checks++;
                    if (k - last_acc !== 3) begin
                        failures++;
                        $display("FAIL b2b spacing: %0d cycles want 3", k - last_acc);
                    end
                end
                last_acc = k;
            end
            checks++;
            if (rsp_valid && prev_rsp) begin
                failures++;
                $display("FAIL b2b rsp_pulse: rsp_valid high two cycles in a row at %0d", k);
            end
            if (rsp_valid) begin
                n_rsp++;
                checks++;
                if (rsp_rdata !== 32'h0000_1234 || rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b rdata: rdata=%h err=%b want 00001234 0", rsp_rdata, rsp_err);
                end
            end
            prev_rdy = cmd_ready; prev_rsp = rsp_valid;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n_acc !== 5 || n_rsp !== 4) begin
            failures++;
            $display("FAIL b2b counts: accepts=%0d responses=%0d want 5 4", n_acc, n_rsp);
        end
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        pready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        pready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 || paddr !== 0 || pwdata !== 0 ||
            rsp_rdata !== 0) begin
            failures++;
            $display("FAIL reset_mid: psel=%b pen=%b pw=%b rv=%b re=%b paddr=%h rdata=%h want 0",
                     psel, penable, pwrite, rsp_valid, rsp_err, paddr, rsp_rdata);
        end
        pready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || psel !== 1'b0) seen++;
        end
        pready = 1'b0;
        checks++;
        if (seen !== 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after: stray_cycles=%0d rdy=%b want 0 1", seen, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        do_xfer(1'b0, 32'd9, 32'h0, TO - 1, 1'b0, "ready_at_limit");
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd9;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        pready = 1'b0;
        @(posedge clk); #1;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
`ifdef APB_TIMEOUT_EN
        checks++;
        if (!got || n !== TO || rsp_err !== 1'b1 || rsp_rdata !== 0 || psel !== 1'b0 || penable !== 1'b0) begin
            failures++;
            $display("FAIL timeout: got=%b waits=%0d err=%b rdata=%h psel=%b want 1 %0d 1 0 0",
                     got, n, rsp_err, rsp_rdata, psel, TO);
        end
        @(posedge clk); #1;
`else
        checks++;
        if (got || psel !== 1'b1 || penable !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout: rsp_seen=%b psel=%b pen=%b want 0 1 1", got, psel, penable);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        do_xfer(1'b0, 32'd5, 32'h0, 0, 1'b0, "after_timeout");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
